bram_stream_reader: RTL

Streaming read engine for the simple dual-port block RAM's synchronous read port. It accepts a burst command (base address and length), drives the RAM read address, and absorbs the RAM's fixed one-cycle read latency. It presents the words on a valid/ready stream with a last-beat marker and full backpressure support. It sits between a BRAM (for example a framebuffer or line buffer) and a downstream consumer such as a pixel pipeline.

---
 rtl/bram_stream_reader.sv | 139 +++++++++++++
 1 files changed

// File: rtl/bram_stream_reader.sv
// Burst read engine for a synchronous-read BRAM port. Issues addresses under a
// two-entry credit window, captures the one-cycle-late read data into a small
// FIFO and presents it on a valid/ready stream with a last-beat marker.
module bram_stream_reader #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 256,
  parameter int unsigned ADDRW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [ADDRW-1:0] base_addr,
  input  logic [ADDRW:0]   len,
  output logic [ADDRW-1:0] addr_read,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             busy,
  output logic             done
);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e           state_q, state_d;
  logic [ADDRW:0]   remaining_q, remaining_d;
  logic [ADDRW:0]   beats_q, beats_d;
  logic [ADDRW-1:0] addr_d;
  logic             inflight_q, inflight_d;
  logic             lead_q, lead_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] fifo_q [2];
  logic             wr_ptr_q, rd_ptr_q;
  logic [1:0]       count_q;

  logic             pop, push, issue;

  assign pop       = out_valid & out_ready;
  assign push      = inflight_q;
  assign out_valid = (count_q != 2'd0);
  assign out_data  = fifo_q[rd_ptr_q];
  assign out_last  = out_valid & (beats_q == (ADDRW+1)'(1));
  assign busy      = (state_q == StRun);
  assign done      = done_q;

  // Credit check: slots held plus the read in flight, less what leaves this edge, stays below 2.
  always_comb begin
    issue = (state_q == StRun) && (remaining_q != '0) &&
            ({1'b0, count_q} + {2'b00, inflight_q} < 3'd2 + {2'b00, pop});
  end

  // Next-state, address and burst bookkeeping.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    beats_d     = beats_q;
    addr_d      = addr_read;
    inflight_d  = issue;
    lead_d      = 1'b0;
    done_d      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d     = StRun;
          remaining_d = len;
          beats_d     = len;
          addr_d      = base_addr;
          lead_d      = 1'b1;
        end
      end
      StRun: begin
        if (issue) begin
          addr_d      = (addr_read == ADDRW'(DEPTH - 1)) ? '0 : addr_read + 1'b1;
          remaining_d = remaining_q - 1'b1;
        end
        if (pop) begin
          beats_d = beats_q - 1'b1;
        end
        // A zero-length burst still waits out the normal two-edge first-beat latency.
        if ((pop && beats_q == (ADDRW+1)'(1)) || (beats_q == '0 && !lead_q)) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      remaining_q <= '0;
      beats_q     <= '0;
      addr_read   <= '0;
      inflight_q  <= 1'b0;
      lead_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      beats_q     <= beats_d;
      addr_read   <= addr_d;
      inflight_q  <= inflight_d;
      lead_q      <= lead_d;
      done_q      <= done_d;
    end
  end

  // Two-entry capture FIFO for the RAM read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      count_q   <= 2'd0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr_q] <= data_in;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  // The credit rule makes a push into a full FIFO unreachable.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (!(push && !pop && count_q == 2'd2));
    end
  end

endmodule
